uart_tx_scheduler: RTL and testbench

- Shares one UART transmitter (9600 baud at 1 MHz, 104 clocks/bit) between NUM_REQ byte requesters.
- Round-robin arbitration; latches the winner's byte, drives the transmitter's load strobe and waits for frame completion.
- Enforces an inter-frame idle gap and flags a transmitter that never starts.
- Sits between client logic and the UART TX datapath in the UART top.

---
 rtl/uart_tx_scheduler.sv | 97 +++++++++
 tb/tb_uart_tx_scheduler.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter feeding one UART transmitter with load strobe, idle gap and start timeout
module uart_tx_scheduler #(
  parameter int NUM_REQ       = 4,
  parameter int LOAD_CYCLES   = 104,
  parameter int GAP_CYCLES    = 208,
  parameter int START_TIMEOUT = 1040
) (
  input  logic                 clk_1MHz,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 tx_load,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [2:0]           active_id,
  output logic                 frame_done,
  output logic                 err_timeout
);
  localparam int MAX_LG = (LOAD_CYCLES > GAP_CYCLES) ? LOAD_CYCLES : GAP_CYCLES;
  localparam int MAX_C  = (MAX_LG > START_TIMEOUT) ? MAX_LG : START_TIMEOUT;
  localparam int CW     = $clog2(MAX_C + 1);
  localparam logic [CW-1:0] LOAD_END = CW'(LOAD_CYCLES - 1);
  localparam logic [CW-1:0] TO_END   = CW'(START_TIMEOUT - 1);
  localparam logic [CW-1:0] GAP_END  = CW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
  localparam logic [3:0]    NR       = 4'(NUM_REQ);
  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] LOAD       = 3'd1;
  localparam logic [2:0] WAIT_START = 3'd2;
  localparam logic [2:0] WAIT_DONE  = 3'd3;
  localparam logic [2:0] GAP        = 3'd4;
  localparam logic [2:0] POST       = (GAP_CYCLES == 0) ? IDLE : GAP;
  logic [2:0]         state, rr, off, win;
  logic [CW-1:0]      cnt;
  logic [NUM_REQ-1:0] rot;
  logic [3:0]         sum;
  // rotate requests so the rr pointer sits at bit 0, take the lowest set bit, then map back to a client index
  always_comb begin
    rot = NUM_REQ'({req, req} >> rr);
    off = 3'd0;
    for (int i = NUM_REQ - 1; i >= 0; i--) off = rot[i] ? 3'(i) : off;
    sum = {1'b0, rr} + {1'b0, off};
    win = (sum >= NR) ? 3'(sum - NR) : sum[2:0];
  end
  // grant, load strobe, completion wait and gap sequencing
  always_ff @(posedge clk_1MHz or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      rr          <= 3'd0;
      cnt         <= '0;
      ack         <= '0;
      tx_load     <= 1'b0;
      tx_data     <= 8'h00;
      active_id   <= 3'd0;
      frame_done  <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      ack        <= '0;
      frame_done <= 1'b0;
      case (state)
        IDLE: if (|req) begin
          tx_data   <= 8'(req_data >> {win, 3'b000});
          active_id <= win;
          ack       <= NUM_REQ'(1) << win;
          rr        <= (win == 3'(NUM_REQ - 1)) ? 3'd0 : win + 3'd1;
          tx_load   <= 1'b1;
          cnt       <= '0;
          state     <= LOAD;
        end
        LOAD: if (cnt == LOAD_END) begin
          tx_load <= 1'b0;
          cnt     <= '0;
          state   <= WAIT_START;
        end else cnt <= cnt + 1'b1;
        WAIT_START: if (tx_busy) begin
          cnt   <= '0;
          state <= WAIT_DONE;
        end else if (cnt == TO_END) begin
          err_timeout <= 1'b1;
          frame_done  <= 1'b1;
          cnt         <= '0;
          state       <= POST;
        end else cnt <= cnt + 1'b1;
        WAIT_DONE: if (!tx_busy) begin
          frame_done <= 1'b1;
          cnt        <= '0;
          state      <= POST;
        end
        GAP: if (cnt == GAP_END) begin
          cnt   <= '0;
          state <= IDLE;
        end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: scoreboard bench for the shared UART transmit scheduler
`timescale 1ns/1ps
module tb_uart_tx_scheduler;
  localparam int N = 4;
  logic           clk_1MHz = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   ack;
  logic           tx_load;
  logic [7:0]     tx_data;
  logic           tx_busy = 1'b0;
  logic [2:0]     active_id;
  logic           frame_done;
  logic           err_timeout;

  uart_tx_scheduler #(.NUM_REQ(N), .LOAD_CYCLES(104), .GAP_CYCLES(208), .START_TIMEOUT(1040)) dut (
    .clk_1MHz(clk_1MHz), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
    .tx_load(tx_load), .tx_data(tx_data), .tx_busy(tx_busy), .active_id(active_id),
    .frame_done(frame_done), .err_timeout(err_timeout)
  );

  always #500 clk_1MHz = ~clk_1MHz;

  typedef struct {int id; logic [7:0] data;} exp_t;
  exp_t exp_q[$];
  int n_chk = 0, n_fail = 0, cyc = 0, fd_cnt = 0, ack_cnt = 0;
  int fd_cyc = 0, rise_cyc = 0, fall_cyc = 0, err_cyc = 0, bcnt = 0;
  int busy_len = 1040;
  bit busy_en = 1, drop_on_ack = 1, fd_valid = 0;
  logic pl = 0, pe = 0, bl = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk_1MHz) cyc++;

  // output monitor: scoreboard pops on ack, strobe length and gap timing
  always @(negedge clk_1MHz) begin
    exp_t e;
    if (!rst) fd_valid = 0;
    if (ack != 0) begin
      ack_cnt++;
      if (exp_q.size() == 0) chk("ack_unexpected", 32'(ack), 0);
      else begin
        e = exp_q.pop_front();
        chk("ack_onehot", 32'(ack), 32'(1) << e.id);
        chk("active_id", 32'(active_id), e.id);
        chk("tx_data", 32'(tx_data), 32'(e.data));
        chk("load_with_ack", 32'(tx_load), 1);
      end
    end
    if (tx_load && !pl) begin
      rise_cyc = cyc;
      if (fd_valid) chk("gap_before_load", 32'((cyc - fd_cyc) >= 208), 1);
      fd_valid = 0;
    end
    if (!tx_load && pl) begin
      fall_cyc = cyc;
      chk("load_len", cyc - rise_cyc, 104);
    end
    if (frame_done) begin
      fd_cnt++;
      fd_cyc = cyc;
      fd_valid = 1;
    end
    if (err_timeout && !pe) err_cyc = cyc;
    pl = tx_load;
    pe = err_timeout;
  end

  // UART model: busy rises 3 cycles after the load strobe falls and stays high busy_len cycles
  always @(negedge clk_1MHz) begin
    if (!rst) begin
      bcnt = 0;
      tx_busy = 1'b0;
    end else begin
      if (bl && !tx_load && busy_en) bcnt = busy_len + 3;
      else if (bcnt > 0) bcnt--;
      tx_busy = (bcnt > 0 && bcnt <= busy_len);
    end
    bl = tx_load;
  end

  task automatic wait_fd(input int target);
    for (int i = 0; i < 5000 && fd_cnt < target; i++) @(negedge clk_1MHz);
    @(negedge clk_1MHz);
    chk("frame_done_wait", 32'(fd_cnt >= target), 1);
  endtask

  task automatic wait_ack(input int target);
    for (int i = 0; i < 10000 && ack_cnt < target; i++) begin
      @(negedge clk_1MHz);
      if (drop_on_ack) req = req & ~ack;
    end
    @(negedge clk_1MHz);
    chk("ack_wait", 32'(ack_cnt >= target), 1);
  endtask

  task automatic wait_busy;
    for (int i = 0; i < 2000 && !tx_busy; i++) @(negedge clk_1MHz);
    chk("busy_wait", 32'(tx_busy), 1);
  endtask

  task automatic do_reset;
    @(negedge clk_1MHz);
    rst = 1'b0;
    repeat (3) @(negedge clk_1MHz);
    rst = 1'b1;
    @(negedge clk_1MHz);
  endtask

  task automatic give(input int id, input logic [7:0] b);
    req_data[8*id +: 8] = b;
    exp_q.push_back('{id, b});
  endtask

  initial begin
    #100_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, f;
    repeat (3) @(negedge clk_1MHz);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_tx_load", 32'(tx_load), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_active_id", 32'(active_id), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_err", 32'(err_timeout), 0);
    rst = 1'b1;
    @(negedge clk_1MHz);
    // single request, one cycle latency
    give(1, 8'h96);
    req = 4'b0010;
    @(posedge clk_1MHz); #1;
    chk("t1_ack", 32'(ack), 32'h2);
    chk("t1_data", 32'(tx_data), 32'h96);
    chk("t1_id", 32'(active_id), 1);
    chk("t1_load", 32'(tx_load), 1);
    @(negedge clk_1MHz);
    req = '0;
    wait_fd(1);
    chk("t1_err", 32'(err_timeout), 0);
    chk("t1_fd_count", fd_cnt, 1);
    // round robin with everyone requesting
    do_reset;
    drop_on_ack = 0;
    for (int i = 0; i < 4; i++) give(i, 8'hA0 + 8'(i));
    give(0, 8'hA0);
    base = ack_cnt;
    f = fd_cnt;
    req = 4'b1111;
    wait_ack(base + 5);
    req = '0;
    drop_on_ack = 1;
    wait_fd(f + 5);
    chk("rr_ack_count", ack_cnt - base, 5);
    // wrap-around priority after a grant to client 3
    do_reset;
    give(3, 8'hC3);
    req = 4'b1000;
    wait_ack(ack_cnt + 1);
    wait_fd(fd_cnt + 1);
    give(0, 8'hB0);
    exp_q.push_back('{3, 8'hD3});
    req_data[31:24] = 8'hD3;
    req = 4'b1001;
    base = ack_cnt;
    wait_ack(base + 2);
    wait_fd(fd_cnt + 1);
    // start timeout with a silent transmitter
    busy_en = 0;
    give(0, 8'h77);
    f = fd_cnt;
    req = 4'b0001;
    wait_ack(ack_cnt + 1);
    for (int i = 0; i < 3000 && !err_timeout; i++) @(negedge clk_1MHz);
    @(negedge clk_1MHz);
    chk("to_err_set", 32'(err_timeout), 1);
    chk("to_delay", err_cyc - fall_cyc, 1040);
    chk("to_fd_count", fd_cnt, f + 1);
    chk("to_fd_same_cycle", fd_cyc, err_cyc);
    busy_en = 1;
    give(1, 8'h42);
    req = 4'b0010;
    wait_ack(ack_cnt + 1);
    chk("to_sticky", 32'(err_timeout), 1);
    wait_fd(fd_cnt + 1);
    chk("to_sticky_after", 32'(err_timeout), 1);
    // reset in the middle of a frame
    give(0, 8'h11);
    req = 4'b0001;
    wait_ack(ack_cnt + 1);
    wait_busy;
    repeat (20) @(negedge clk_1MHz);
    req_data[23:16] = 8'h5C;
    req = 4'b0100;
    f = fd_cnt;
    base = ack_cnt;
    #200 rst = 1'b0;
    #10;
    chk("mid_rst_load", 32'(tx_load), 0);
    chk("mid_rst_data", 32'(tx_data), 0);
    chk("mid_rst_err", 32'(err_timeout), 0);
    chk("mid_rst_ack", 32'(ack), 0);
    chk("mid_rst_fd", 32'(frame_done), 0);
    exp_q.push_back('{2, 8'h5C});
    @(negedge clk_1MHz);
    @(negedge clk_1MHz);
    rst = 1'b1;
    wait_ack(base + 1);
    chk("mid_rst_no_fd", fd_cnt, f);
    wait_fd(f + 1);
    // back-to-back request pending when the frame finishes
    give(0, 8'h21);
    req = 4'b0001;
    wait_ack(ack_cnt + 1);
    wait_busy;
    give(1, 8'h35);
    req = 4'b0010;
    wait_fd(fd_cnt + 1);
    f = fd_cyc;
    wait_ack(ack_cnt + 1);
    chk("b2b_gap", 32'((rise_cyc - f) >= 208 && (rise_cyc - f) <= 209), 1);
    wait_fd(fd_cnt + 1);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
